// File: rtl/audio_clk_pkg.sv
// ----------------------------------------------------------------------------
// audio_clk_pkg
//
// Shared types and constants for the audio clock sequencer.
//   seqState_t      : sequencer state (IDLE, RUN, STOPPING)
//   CNT_W_DEFAULT   : default width of every divide counter / config field
//   DEF_*           : divide ratios loaded into the active config at reset
//   clkCfg_t        : one complete divider configuration at default width
//   DEF_CFG         : reset configuration packed as a clkCfg_t
// ----------------------------------------------------------------------------
package audio_clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } seqState_t;

    localparam int CNT_W_DEFAULT  = 16;

    // baseClk cycles per MCLK half-period
    localparam int DEF_MCLK_HALF  = 4;
    // MCLK periods per BCLK half-period
    localparam int DEF_BCLK_HALF  = 2;
    // BCLK periods per LRCLK half-period
    localparam int DEF_FRAME_HALF = 32;

    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] mclkHalf;
        logic [CNT_W_DEFAULT-1:0] bclkHalf;
        logic [CNT_W_DEFAULT-1:0] frameHalf;
    } clkCfg_t;

    localparam clkCfg_t DEF_CFG = '{
        mclkHalf:  CNT_W_DEFAULT'(DEF_MCLK_HALF),
        bclkHalf:  CNT_W_DEFAULT'(DEF_BCLK_HALF),
        frameHalf: CNT_W_DEFAULT'(DEF_FRAME_HALF)
    };

endpackage

// File: rtl/audio_clk_sequencer_half_period_toggler.sv
// ----------------------------------------------------------------------------
// half_period_toggler
//
// One stage of the clock divider chain. Counts 'advance' pulses and flips its
// output level after 'half' of them, so the level has a period of 2*half
// advances. The same block produces MCLK (advanced every running cycle),
// BCLK (advanced by MCLK falls) and LRCLK (advanced by BCLK falls).
//
// Ports:
//   baseClk  in   system clock
//   rstN     in   asynchronous active-low reset
//   advance  in   count one step this cycle
//   clear    in   force counter and level to 0 (wins over advance)
//   half     in   advances per half-period, must be >= 1
//   level    out  registered divided clock level
//   fall     out  combinational: level goes 1->0 at the end of this cycle
// ----------------------------------------------------------------------------
module half_period_toggler #(
    parameter int CNT_W = 16
) (
    input  logic             baseClk,
    input  logic             rstN,
    input  logic             advance,
    input  logic             clear,
    input  logic [CNT_W-1:0] half,
    output logic             level,
    output logic             fall
);

    logic [CNT_W-1:0] cnt;
    logic             atEnd;

    assign atEnd = (cnt == (half - CNT_W'(1)));

    // Not gated by 'clear': the top derives 'clear' from the last stage's
    // fall strobe, and a clear only ever lands where every level is about to
    // fall anyway, so leaving it out keeps the chain free of loops.
    assign fall  = advance & atEnd & level;

    always_ff @(posedge baseClk or negedge rstN) begin
        if (!rstN) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (advance) begin
            if (atEnd) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/audio_clk_sequencer.sv
// ----------------------------------------------------------------------------
// audio_clk_sequencer
//
// Generates MCLK, BCLK and LRCLK for the codec from baseClk with run-time
// divide ratios. Starting is immediate; stopping waits for the next frame
// boundary (the cycle LRCLK falls, where MCLK and BCLK fall too), so the
// serializer never sees a partial frame. New ratios offered while running are
// parked in a shadow register and take effect on the next frame boundary.
//
// Optional build macro: AUDIO_CLK_SEQ_FRAMECNT_EN adds output frameCount.
//
// Ports:
//   baseClk       in   system clock, rising edge
//   rstN          in   asynchronous active-low reset
//   enable        in   1 = run, 0 = stop at the next frame boundary
//   cfgValid      in   configuration offered
//   cfgReady      out  configuration can be accepted
//   cfgMclkHalf   in   MCLK half-period in baseClk cycles (0 acts as 1)
//   cfgBclkHalf   in   BCLK half-period in MCLK periods (0 acts as 1)
//   cfgFrameHalf  in   LRCLK half-period in BCLK periods (0 acts as 1)
//   mclk          out  registered MCLK
//   bclk          out  registered BCLK
//   lrclk         out  registered LRCLK, 0 = left channel
//   frameStart    out  one-cycle strobe in the cycle after the boundary edge,
//                      i.e. the first cycle with all clocks low
//   running       out  high while in RUN or STOPPING
//   seqState      out  current sequencer state (debug)
//   frameCount    out  frames since start, wraps (only with the macro)
//
// Handshake: a configuration transfers on a rising edge where cfgValid and
// cfgReady are both high. The offer must stay stable while cfgValid is high
// and cfgReady low; cfgReady never depends on cfgValid.
// ----------------------------------------------------------------------------
module audio_clk_sequencer
    import audio_clk_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int DEF_MCLK_HALF  = audio_clk_pkg::DEF_MCLK_HALF,
    parameter int DEF_BCLK_HALF  = audio_clk_pkg::DEF_BCLK_HALF,
    parameter int DEF_FRAME_HALF = audio_clk_pkg::DEF_FRAME_HALF
) (
    input  logic             baseClk,
    input  logic             rstN,
    input  logic             enable,
    input  logic             cfgValid,
    output logic             cfgReady,
    input  logic [CNT_W-1:0] cfgMclkHalf,
    input  logic [CNT_W-1:0] cfgBclkHalf,
    input  logic [CNT_W-1:0] cfgFrameHalf,
    output logic             mclk,
    output logic             bclk,
    output logic             lrclk,
    output logic             frameStart,
    output logic             running,
    output seqState_t        seqState
`ifdef AUDIO_CLK_SEQ_FRAMECNT_EN
    ,
    output logic [15:0]      frameCount
`endif
);

    // Same layout as clkCfg_t, but sized by this instance's CNT_W.
    typedef struct packed {
        logic [CNT_W-1:0] mclkHalf;
        logic [CNT_W-1:0] bclkHalf;
        logic [CNT_W-1:0] frameHalf;
    } cfg_t;

    localparam cfg_t RESET_CFG = '{
        mclkHalf:  CNT_W'(DEF_MCLK_HALF),
        bclkHalf:  CNT_W'(DEF_BCLK_HALF),
        frameHalf: CNT_W'(DEF_FRAME_HALF)
    };

    // A zero ratio is meaningless; it behaves as a ratio of one.
    function automatic logic [CNT_W-1:0] nonZero(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    seqState_t state;
    cfg_t      activeCfg;
    cfg_t      shadowCfg;
    cfg_t      offeredCfg;
    logic      pending;

    logic      clocksOn;
    logic      mclkFall;
    logic      bclkFall;
    logic      lrclkFall;
    logic      boundary;
    logic      applyShadow;
    logic      togglerClear;
    logic      cfgXfer;

    assign clocksOn     = (state != IDLE);
    // Every stage falls together here, so this is the frame boundary cycle.
    assign boundary     = lrclkFall;
    assign applyShadow  = boundary & pending;
    assign togglerClear = (state == IDLE) | applyShadow;
    assign cfgXfer      = cfgValid & cfgReady;
    assign seqState     = state;

    assign offeredCfg.mclkHalf  = nonZero(cfgMclkHalf);
    assign offeredCfg.bclkHalf  = nonZero(cfgBclkHalf);
    assign offeredCfg.frameHalf = nonZero(cfgFrameHalf);

    half_period_toggler #(.CNT_W(CNT_W)) u_mclk (
        .baseClk (baseClk),
        .rstN    (rstN),
        .advance (clocksOn),
        .clear   (togglerClear),
        .half    (activeCfg.mclkHalf),
        .level   (mclk),
        .fall    (mclkFall)
    );

    half_period_toggler #(.CNT_W(CNT_W)) u_bclk (
        .baseClk (baseClk),
        .rstN    (rstN),
        .advance (mclkFall),
        .clear   (togglerClear),
        .half    (activeCfg.bclkHalf),
        .level   (bclk),
        .fall    (bclkFall)
    );

    half_period_toggler #(.CNT_W(CNT_W)) u_lrclk (
        .baseClk (baseClk),
        .rstN    (rstN),
        .advance (bclkFall),
        .clear   (togglerClear),
        .half    (activeCfg.frameHalf),
        .level   (lrclk),
        .fall    (lrclkFall)
    );

    // Sequencer FSM with its registered status outputs.
    always_ff @(posedge baseClk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            running    <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= boundary;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    // Re-enabling resumes without touching the counters.
                    if (enable) begin
                        state <= RUN;
                    end else if (boundary) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Configuration path. cfgReady is low exactly while a shadow value waits
    // for its boundary, so an apply and a new transfer never coincide. A
    // transfer on a boundary cycle finds pending clear and waits for the
    // following boundary.
    always_ff @(posedge baseClk or negedge rstN) begin
        if (!rstN) begin
            activeCfg <= RESET_CFG;
            shadowCfg <= RESET_CFG;
            pending   <= 1'b0;
            cfgReady  <= 1'b1;
        end else if (applyShadow) begin
            activeCfg <= shadowCfg;
            pending   <= 1'b0;
            cfgReady  <= 1'b1;
        end else if (cfgXfer) begin
            if (state == IDLE) begin
                activeCfg <= offeredCfg;
            end else begin
                shadowCfg <= offeredCfg;
                pending   <= 1'b1;
                cfgReady  <= 1'b0;
            end
        end
    end

`ifdef AUDIO_CLK_SEQ_FRAMECNT_EN
    always_ff @(posedge baseClk or negedge rstN) begin
        if (!rstN) begin
            frameCount <= 16'd0;
        end else if ((state == IDLE) && enable) begin
            frameCount <= 16'd0;
        end else if (boundary) begin
            frameCount <= frameCount + 16'd1;
        end
    end
`endif

endmodule
